// File: rtl/storage_access_arbiter.sv
// Registered req/gnt arbiter sharing the single-port Matrix_storage RAM between input(0), display(1), calc(2).
// Define STORAGE_ARB_RR_EN for round-robin winner selection; otherwise fixed priority calc > input > display.
module storage_access_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err_oob,
    output logic                busy,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CNT_W = $clog2(MAX_BURST + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = (MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_BURST);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [2:0]         rvalid_q, rvalid_d;
    logic               err_oob_q, err_oob_d;
    logic               rd_oob_q, rd_oob_d;

    logic               beat;
    logic               regrant;
    logic               in_bounds;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [2:0]         cand;
    logic [1:0]         winner;

`ifdef STORAGE_ARB_RR_EN
    // rr_ptr holds the first index to consider, i.e. the slot just after the last owner
    logic [1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [1:0] pick_winner(input logic [2:0] c, input logic [1:0] start);
        int s;
        pick_winner = 2'd0;
        for (int off = 2; off >= 0; off--) begin
            s = int'(start) + off;
            if (s >= 3) s = s - 3;
            if (c[s]) pick_winner = 2'(s);
        end
    endfunction

    assign winner = pick_winner(cand, rr_ptr_q);
`else
    function automatic logic [1:0] pick_winner(input logic [2:0] c);
        if (c[2])      pick_winner = 2'd2;
        else if (c[0]) pick_winner = 2'd0;
        else           pick_winner = 2'd1;
    endfunction

    assign winner = pick_winner(cand);
`endif

    assign beat      = |(req & gnt_q);
    assign cand      = beat ? (req & ~gnt_q) : req;
    assign in_bounds = ({1'b0, sel_addr} < DEPTH_L);

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (owner_q)
            2'd0: begin
                sel_we    = we[0];
                sel_addr  = addr[0 +: ADDR_W];
                sel_wdata = wdata[0 +: DATA_W];
            end
            2'd1: begin
                sel_we    = we[1];
                sel_addr  = addr[ADDR_W +: ADDR_W];
                sel_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_we    = we[2];
                sel_addr  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // In OWN, a cycle without a beat means the owner dropped req; that release wins over the burst limit
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        regrant    = 1'b0;
        if (beat && beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + 1'b1;
        case (state_q)
            IDLE: regrant = |req;
            OWN: begin
                if (!beat) begin
                    regrant = 1'b1;
                    if (!(|req)) state_d = IDLE;
                end else if (MAX_BURST != 0 && beat_cnt_d == CNT_MAX && |cand) begin
                    regrant = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (regrant) begin
            beat_cnt_d = '0;
            if (|cand) begin
                state_d = OWN;
                owner_d = winner;
            end
        end
        gnt_d = (state_d == OWN) ? 3'(3'b001 << owner_d) : 3'b000;
    end

`ifdef STORAGE_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (regrant && |cand) rr_ptr_d = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= 2'd0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        rvalid_d  = (beat && !sel_we) ? gnt_q : 3'b000;
        rd_oob_d  = beat && !sel_we && !in_bounds;
        err_oob_d = beat && !in_bounds;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            gnt_q      <= 3'b000;
            beat_cnt_q <= '0;
            rvalid_q   <= 3'b000;
            err_oob_q  <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
            err_oob_q  <= err_oob_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = |gnt_q;
    assign rvalid    = rvalid_q;
    assign err_oob   = err_oob_q;
    assign rdata     = rd_oob_q ? '0 : mem_rdata;
    assign mem_we    = beat && sel_we && in_bounds;
    assign mem_addr  = beat ? sel_addr : '0;
    assign mem_wdata = beat ? sel_wdata : '0;

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Scoreboard bench for storage_access_arbiter (DEPTH=100, MAX_BURST=4) with a 1-cycle-latency RAM model.
// Stimulus queues expected grant order and read responses; an independent monitor pops and compares.
module tb_storage_access_arbiter;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 100;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                err_oob;
    logic                busy;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    logic [DATA_W-1:0]   ram [256];

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      gnt_exp_q[$];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int beats[3] = '{0, 0, 0};
    int we_cnt[3] = '{0, 0, 0};
    int err_cnt = 0;
    int gap_cnt = 0;
    int busy_bad = 0;

    storage_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err_oob(err_oob), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [2:0] onehot(input int id);
        logic [2:0] r;
        r = 3'b000;
        r[id] = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Drives one requester for n beats; addr/wdata step by one per beat, reads expect d0
    task automatic applyStimulus(input int id, input int n, input logic wr,
                                 input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0);
        int got;
        int waited;
        got = 0;
        waited = 0;
        we[id] = wr;
        addr[id*ADDR_W +: ADDR_W] = a0;
        wdata[id*DATA_W +: DATA_W] = d0;
        req[id] = 1'b1;
        while (got < n && waited < 200) begin
            @(negedge clk);
            waited++;
            if (gnt[id]) begin
                if (!wr) rd_q.push_back('{id, d0, cycle + 1});
                got++;
                @(posedge clk);
                #1;
                addr[id*ADDR_W +: ADDR_W] = a0 + ADDR_W'(got);
                wdata[id*DATA_W +: DATA_W] = d0 + DATA_W'(got);
            end
        end
        req[id] = 1'b0;
        if (got < n) checkOutput("burst_timeout", 32'(got), 32'(n));
    endtask

    task automatic idle_wait();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic issue_latency_read(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        gnt_exp_q.push_back(id);
        @(posedge clk);
        #1;
        we[id] = 1'b0;
        addr[id*ADDR_W +: ADDR_W] = a;
        req[id] = 1'b1;
        @(negedge clk);
        checkOutput("gnt_same_cycle", 32'(gnt), 32'd0);
        checkOutput("busy_same_cycle", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("gnt_next_cycle", 32'(gnt), 32'(onehot(id)));
        checkOutput("mem_addr_read", 32'(mem_addr), 32'(a));
        checkOutput("mem_we_read", 32'(mem_we), 32'd0);
        checkOutput("busy_granted", 32'(busy), 32'd1);
        if (gnt[id]) rd_q.push_back('{id, exp, cycle + 1});
        @(posedge clk);
        #1;
        req[id] = 1'b0;
        idle_wait();
    endtask

    task automatic readback(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        gnt_exp_q.push_back(id);
        applyStimulus(id, 1, 1'b0, a, exp);
        idle_wait();
    endtask

    // Monitor: tracks activity counters and pops the scoreboards whenever the DUT presents output
    initial begin
        logic [2:0] prev_gnt;
        rd_exp_t    e;
        int         exp_id;
        prev_gnt = 3'b000;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (req[i] && gnt[i]) beats[i] = beats[i] + 1;
                if (mem_we && gnt[i]) we_cnt[i] = we_cnt[i] + 1;
            end
            if (err_oob) err_cnt++;
            if (req != 3'b000 && gnt == 3'b000) gap_cnt++;
            if (busy !== (gnt != 3'b000)) busy_bad++;
            if (gnt != prev_gnt && gnt != 3'b000) begin
                if (gnt_exp_q.size() == 0) begin
                    checkOutput("grant_unexpected", 32'(gnt), 32'd0);
                end else begin
                    exp_id = gnt_exp_q.pop_front();
                    checkOutput("grant_order", 32'(gnt), 32'(onehot(exp_id)));
                end
            end
            prev_gnt = gnt;
            if (rvalid != 3'b000) begin
                if (rd_q.size() == 0) begin
                    checkOutput("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    checkOutput("rvalid_id", 32'(rvalid), 32'(onehot(e.id)));
                    checkOutput("rdata", rdata, e.data);
                    checkOutput("rvalid_latency", 32'(cycle), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap_a;
        int snap_b;
        int snap_c;
        int w;
        int n6;

        rst   = 1'b1;
        req   = 3'b111;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_err_oob", 32'(err_oob), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        req = 3'b000;
        rst = 1'b0;
        idle_wait();

        // Preload addr 5 through the input port, then a display read with latency checks
        gnt_exp_q.push_back(0);
        applyStimulus(0, 1, 1'b1, 8'd5, 32'hDEADBEEF);
        idle_wait();
        issue_latency_read(1, 8'd5, 32'hDEADBEEF);

        // All three request two write beats at once: calc, input, display
        snap_a = beats[0] + beats[1] + beats[2];
        snap_b = gap_cnt;
        gnt_exp_q.push_back(2);
        gnt_exp_q.push_back(0);
        gnt_exp_q.push_back(1);
        @(posedge clk);
        #1;
        fork
            applyStimulus(2, 2, 1'b1, 8'd10, 32'hC0DE0000);
            applyStimulus(0, 2, 1'b1, 8'd20, 32'hA0000000);
            applyStimulus(1, 2, 1'b1, 8'd30, 32'hD0000000);
        join
        idle_wait();
        checkOutput("three_way_beats", 32'(beats[0] + beats[1] + beats[2] - snap_a), 32'd6);
        checkOutput("three_way_gap", 32'(gap_cnt - snap_b), 32'd1);
        readback(2, 8'd10, 32'hC0DE0000);
        readback(2, 8'd11, 32'hC0DE0001);
        readback(2, 8'd20, 32'hA0000000);
        readback(2, 8'd21, 32'hA0000001);
        readback(2, 8'd30, 32'hD0000000);
        readback(2, 8'd31, 32'hD0000001);

        // Calc streams 10 writes; input arrives one cycle later and gets in after 4 calc beats
        snap_a = beats[2];
        snap_b = we_cnt[2];
        gnt_exp_q.push_back(2);
        gnt_exp_q.push_back(0);
        gnt_exp_q.push_back(2);
        @(posedge clk);
        #1;
        fork
            applyStimulus(2, 10, 1'b1, 8'd40, 32'h30000000);
            begin
                @(posedge clk);
                #1;
                applyStimulus(0, 1, 1'b1, 8'd60, 32'h600DF00D);
            end
            begin
                w = 0;
                while (!gnt[0] && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput("burst_len_before_input", 32'(beats[2] - snap_a), 32'd4);
            end
        join
        idle_wait();
        checkOutput("calc_mem_we_pulses", 32'(we_cnt[2] - snap_b), 32'd10);
        readback(1, 8'd49, 32'h30000009);
        readback(1, 8'd60, 32'h600DF00D);

        // Out-of-bounds write and read
        snap_a = we_cnt[0] + we_cnt[1] + we_cnt[2];
        snap_c = err_cnt;
        gnt_exp_q.push_back(0);
        applyStimulus(0, 1, 1'b1, 8'd100, 32'hBAD0BAD0);
        idle_wait();
        checkOutput("oob_write_mem_we", 32'(we_cnt[0] + we_cnt[1] + we_cnt[2] - snap_a), 32'd0);
        checkOutput("oob_write_err", 32'(err_cnt - snap_c), 32'd1);
        readback(1, 8'd120, 32'h00000000);
        checkOutput("oob_read_err", 32'(err_cnt - snap_c), 32'd2);
        readback(2, 8'd5, 32'hDEADBEEF);

        // Reset during beat 3 of a calc burst
        gnt_exp_q.push_back(2);
        @(posedge clk);
        #1;
        we[2] = 1'b1;
        addr[2*ADDR_W +: ADDR_W] = 8'd70;
        wdata[2*DATA_W +: DATA_W] = 32'h70707070;
        req[2] = 1'b1;
        n6 = 0;
        w = 0;
        while (n6 < 3 && w < 200) begin
            @(negedge clk);
            w++;
            if (gnt[2]) begin
                n6++;
                if (n6 < 3) begin
                    @(posedge clk);
                    #1;
                    addr[2*ADDR_W +: ADDR_W] = addr[2*ADDR_W +: ADDR_W] + 8'd1;
                end
            end
        end
        rst = 1'b1;
        checkOutput("beats_before_reset", 32'(n6), 32'd3);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(negedge clk);
        checkOutput("midreset_gnt", 32'(gnt), 32'd0);
        checkOutput("midreset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_err_oob", 32'(err_oob), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_latency_read(1, 8'd5, 32'hDEADBEEF);

`ifdef STORAGE_ARB_RR_EN
        // Round-robin from a fresh reset: single beats repeated by all three
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            gnt_exp_q.push_back(0);
            gnt_exp_q.push_back(1);
            gnt_exp_q.push_back(2);
        end
        fork
            for (int k = 0; k < 2; k++) begin
                applyStimulus(0, 1, 1'b1, 8'd80, 32'h80000000);
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < 2; k++) begin
                applyStimulus(1, 1, 1'b1, 8'd81, 32'h81000000);
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < 2; k++) begin
                applyStimulus(2, 1, 1'b1, 8'd82, 32'h82000000);
                @(posedge clk);
                #1;
            end
        join
        idle_wait();
`endif

        idle_wait();
        checkOutput("grant_queue_drained", 32'(gnt_exp_q.size()), 32'd0);
        checkOutput("read_queue_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("busy_tracks_gnt", 32'(busy_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
